// File: rtl/cnn_uart_pkg.sv
// Shared types and protocol constants for the UART frame loader.
package cnn_uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_PAYLOAD,
    ST_CSUM,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_PING  = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/uart_byte_timer.sv
// Reloadable down-counter measuring idle cycles between received bytes.
// expired fires on the TIMEOUT_CYC-th consecutive enabled cycle after a reload.
module uart_byte_timer #(
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = enable && !reload && (count == CNT_W'(1));

endmodule

// File: rtl/uart_frame_loader.sv
// Parses SYNC/CMD/payload/CSUM frames from the UART receiver, fills the CNN
// input buffer and answers ACK/NAK. Define CHECKSUM_EN to require the CSUM byte.
module uart_frame_loader
  import cnn_uart_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = 784,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rx_rdy,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              good_load_q, good_load_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic              frame_err_q, frame_err_d;
`ifdef CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic in_frame;
  logic timer_expired;

  assign in_frame = (state == ST_CMD) || (state == ST_PAYLOAD) || (state == ST_CSUM);

  // Timer restarts on every consumed byte and stays loaded outside a frame.
  uart_byte_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .reload (!in_frame || clr_rx_rdy),
    .enable (in_frame && !rx_rdy),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HUNT;
      addr_q      <= '0;
      tx_byte_q   <= 8'h00;
      good_load_q <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      frame_err_q <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state       <= state_nxt;
      addr_q      <= addr_d;
      tx_byte_q   <= tx_byte_d;
      good_load_q <= good_load_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      frame_err_q <= frame_err_d;
`ifdef CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_d      = addr_q;
    tx_byte_d   = tx_byte_q;
    good_load_d = good_load_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    frame_err_d = 1'b0;
    clr_rx_rdy  = 1'b0;
    trmt        = 1'b0;
    tx_data     = 8'h00;
    frame_done  = 1'b0;
`ifdef CHECKSUM_EN
    sum_d       = sum_q;
`endif

    unique case (state)
      ST_HUNT: begin
        clr_rx_rdy = rx_rdy;
        if (rx_rdy && (rx_data == SYNC_BYTE)) begin
          state_nxt   = ST_CMD;
          addr_d      = '0;
          good_load_d = 1'b0;
`ifdef CHECKSUM_EN
          sum_d       = 8'h00;
`endif
        end
      end

      ST_CMD: begin
        clr_rx_rdy = rx_rdy;
        if (timer_expired) begin
          state_nxt   = ST_HUNT;
          frame_err_d = 1'b1;
        end else if (rx_rdy) begin
          if (rx_data == CMD_LOAD) begin
            state_nxt   = ST_PAYLOAD;
            good_load_d = 1'b1;
`ifdef CHECKSUM_EN
            sum_d       = rx_data;
`endif
          end else if (rx_data == CMD_PING) begin
`ifdef CHECKSUM_EN
            state_nxt = ST_CSUM;
            sum_d     = rx_data;
`else
            state_nxt = ST_SEND;
            tx_byte_d = ACK_BYTE;
`endif
          end else begin
            state_nxt   = ST_SEND;
            tx_byte_d   = NAK_BYTE;
            frame_err_d = 1'b1;
          end
        end
      end

      ST_PAYLOAD: begin
        clr_rx_rdy = rx_rdy;
        if (timer_expired) begin
          state_nxt   = ST_HUNT;
          frame_err_d = 1'b1;
        end else if (rx_rdy) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = rx_data;
          addr_d      = addr_q + ADDR_W'(1);
`ifdef CHECKSUM_EN
          sum_d       = sum_q + rx_data;
`endif
          if (addr_q == LAST_ADDR) begin
`ifdef CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_SEND;
            tx_byte_d = ACK_BYTE;
`endif
          end
        end
      end

`ifdef CHECKSUM_EN
      ST_CSUM: begin
        clr_rx_rdy = rx_rdy;
        if (timer_expired) begin
          state_nxt   = ST_HUNT;
          frame_err_d = 1'b1;
        end else if (rx_rdy) begin
          state_nxt = ST_SEND;
          if (rx_data == sum_q) begin
            tx_byte_d = ACK_BYTE;
          end else begin
            tx_byte_d   = NAK_BYTE;
            good_load_d = 1'b0;
            frame_err_d = 1'b1;
          end
        end
      end
`endif

      // good_load_q survives only a LOAD that was never NAKed.
      ST_SEND: begin
        trmt       = 1'b1;
        tx_data    = tx_byte_q;
        frame_done = good_load_q;
        state_nxt  = ST_WAIT_TX;
      end

      ST_WAIT_TX: begin
        if (tx_done) begin
          state_nxt = ST_HUNT;
        end
      end

      default: begin
        state_nxt = ST_HUNT;
      end
    endcase
  end

  assign busy      = (state != ST_HUNT);
  assign frame_err = frame_err_q;

endmodule
